// File: rtl/adc_sample_decimator.sv
// Offset-binary ADC to two's complement boxcar decimator (window 2^N) feeding a 2-entry AXI-Stream FIFO.
// Optional macro ADC_DEC_ROUND_EN: round half up before the shift (default: truncate toward -inf).
`timescale 1ns/1ps
module adc_sample_decimator #(
  parameter int DW_IN     = 12,
  parameter int DW        = 16,
  parameter int FRAME_LEN = 1024
) (
  input  logic             hclk,
  input  logic             hresetn,
  input  logic             ce,
  input  logic [DW_IN-1:0] adc_data_i,
  input  logic             adc_valid_i,
  input  logic [2:0]       dec_log2_i,
  input  logic             ovf_clr_i,
  output logic [DW-1:0]    tdata_m,
  output logic             tvalid_m,
  input  logic             tready_m,
  output logic             tlast_m,
  output logic             tuser_m,
  output logic [15:0]      ovf_cnt_o,
  output logic             ovf_o
);

`ifdef ADC_DEC_ROUND_EN
  localparam int ACC_W = DW_IN + 8;
`else
  localparam int ACC_W = DW_IN + 7;
`endif
  localparam int FW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

  logic signed [ACC_W-1:0] r_acc;
  logic signed [ACC_W-1:0] w_sample_ext;
  logic signed [ACC_W-1:0] w_sum;
  logic signed [ACC_W-1:0] w_shift;
`ifdef ADC_DEC_ROUND_EN
  logic signed [ACC_W-1:0] w_rnd;
`endif
  logic [6:0]    r_cnt;
  logic [6:0]    w_win_m;
  logic [2:0]    r_n;
  logic [2:0]    w_n;
  logic          w_last;
  logic          w_push;
  logic          w_pop;
  logic          w_full;
  logic          w_drop;
  logic          w_tag_last;
  logic          w_unused_hi;
  logic [DW-1:0] w_res;
  logic [FW-1:0] r_frame;
  logic          r_tuser_pend;

  logic          r_out_vld, r_out_last, r_out_user;
  logic [DW-1:0] r_out_data;
  logic          r_buf_vld, r_buf_last, r_buf_user;
  logic [DW-1:0] r_buf_data;
  logic [15:0]   r_ovf_cnt;
  logic          r_ovf;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    w_sample_ext = {{(ACC_W-DW_IN+1){~adc_data_i[DW_IN-1]}}, adc_data_i[DW_IN-2:0]};
    // A new window picks up dec_log2_i directly; mid-window the latched copy rules.
    w_n        = (r_cnt == 7'd0) ? dec_log2_i : r_n;
    w_win_m    = ~(7'h7F << w_n);
    w_last     = (r_cnt == w_win_m);
    w_sum      = r_acc + w_sample_ext;
`ifdef ADC_DEC_ROUND_EN
    w_rnd = '0;
    if (w_n != 3'd0) w_rnd[w_n - 3'd1] = 1'b1;
    w_shift = (w_sum + w_rnd) >>> w_n;
`else
    w_shift = w_sum >>> w_n;
`endif
    w_unused_hi = ^w_shift[ACC_W-1:DW_IN];
    w_res = '0;
    w_res[DW-1 -: DW_IN] = w_shift[DW_IN-1:0];
    w_push     = ce & adc_valid_i & w_last;
    w_pop      = r_out_vld & tready_m;
    w_full     = r_out_vld & r_buf_vld;
    w_drop     = w_push & w_full & ~w_pop;
    w_tag_last = (r_frame == FW'(FRAME_LEN - 1));
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      r_acc        <= '0;
      r_cnt        <= '0;
      r_n          <= '0;
      r_frame      <= '0;
      r_tuser_pend <= 1'b1;
    end else begin
      if (r_cnt == 7'd0) r_n <= dec_log2_i;
      if (!ce) begin
        r_acc        <= '0;
        r_cnt        <= '0;
        r_frame      <= '0;
        r_tuser_pend <= 1'b1;
      end else if (adc_valid_i) begin
        if (w_last) begin
          r_acc        <= '0;
          r_cnt        <= '0;
          r_tuser_pend <= 1'b0;
          r_frame      <= w_tag_last ? '0 : r_frame + 1'b1;
        end else begin
          r_acc <= w_sum;
          r_cnt <= r_cnt + 7'd1;
        end
      end
    end
  end

  // NOTE: the two FIFO slots are reset too; outputs must read 0 out of reset, and they are only flops.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      r_out_vld  <= 1'b0;
      r_out_data <= '0;
      r_out_last <= 1'b0;
      r_out_user <= 1'b0;
      r_buf_vld  <= 1'b0;
      r_buf_data <= '0;
      r_buf_last <= 1'b0;
      r_buf_user <= 1'b0;
    end else if (w_pop) begin
      if (r_buf_vld) begin
        r_out_data <= r_buf_data;
        r_out_last <= r_buf_last;
        r_out_user <= r_buf_user;
        if (w_push) begin
          r_buf_data <= w_res;
          r_buf_last <= w_tag_last;
          r_buf_user <= r_tuser_pend;
        end else begin
          r_buf_vld <= 1'b0;
        end
      end else if (w_push) begin
        r_out_data <= w_res;
        r_out_last <= w_tag_last;
        r_out_user <= r_tuser_pend;
      end else begin
        r_out_vld <= 1'b0;
      end
    end else if (w_push) begin
      if (!r_out_vld) begin
        r_out_vld  <= 1'b1;
        r_out_data <= w_res;
        r_out_last <= w_tag_last;
        r_out_user <= r_tuser_pend;
      end else if (!r_buf_vld) begin
        r_buf_vld  <= 1'b1;
        r_buf_data <= w_res;
        r_buf_last <= w_tag_last;
        r_buf_user <= r_tuser_pend;
      end
    end
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      r_ovf_cnt <= '0;
      r_ovf     <= 1'b0;
    end else if (ovf_clr_i) begin
      r_ovf_cnt <= {15'd0, w_drop};
      r_ovf     <= w_drop;
    end else if (w_drop) begin
      if (r_ovf_cnt != 16'hFFFF) r_ovf_cnt <= r_ovf_cnt + 16'd1;
      r_ovf <= 1'b1;
    end
  end

  assign tdata_m   = r_out_data;
  assign tvalid_m  = r_out_vld;
  assign tlast_m   = r_out_last;
  assign tuser_m   = r_out_user;
  assign ovf_cnt_o = r_ovf_cnt;
  assign ovf_o     = r_ovf;

endmodule

// File: tb/tb_adc_sample_decimator.sv
// Directed bench for adc_sample_decimator: stimulus queues expected beats, a negedge monitor compares them.
`timescale 1ns/1ps
module tb_adc_sample_decimator;
  localparam int FL = 4;

  logic        hclk = 1'b0;
  logic        hresetn;
  logic        ce;
  logic [11:0] adc_data_i;
  logic        adc_valid_i;
  logic [2:0]  dec_log2_i;
  logic        ovf_clr_i;
  logic [15:0] tdata_m;
  logic        tvalid_m;
  logic        tready_m;
  logic        tlast_m;
  logic        tuser_m;
  logic [15:0] ovf_cnt_o;
  logic        ovf_o;

  typedef struct packed {
    logic [15:0] data;
    logic        last;
    logic        user;
  } beat_t;

  beat_t q[$];
  beat_t mon_b;
  int    total = 0;
  int    bad   = 0;
  int    m_frame = 0;
  bit    m_pend  = 1'b1;

  adc_sample_decimator #(.DW_IN(12), .DW(16), .FRAME_LEN(FL)) dut (
    .hclk(hclk), .hresetn(hresetn), .ce(ce),
    .adc_data_i(adc_data_i), .adc_valid_i(adc_valid_i), .dec_log2_i(dec_log2_i),
    .ovf_clr_i(ovf_clr_i), .tdata_m(tdata_m), .tvalid_m(tvalid_m), .tready_m(tready_m),
    .tlast_m(tlast_m), .tuser_m(tuser_m), .ovf_cnt_o(ovf_cnt_o), .ovf_o(ovf_o)
  );

  always #5 hclk = ~hclk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Every window completion advances the frame tags; only kept results enter the scoreboard.
  function automatic void exp_push(input logic [15:0] d, input bit kept);
    beat_t b;
    b.data  = d;
    b.last  = (m_frame == FL - 1);
    b.user  = m_pend;
    m_frame = (m_frame + 1) % FL;
    m_pend  = 1'b0;
    if (kept) q.push_back(b);
  endfunction

  always @(negedge hclk) begin
    if (hresetn && tvalid_m && tready_m) begin
      if (q.size() == 0) begin
        check("extra_beat", 32'(q.size()), 32'd1);
      end else begin
        mon_b = q.pop_front();
        check("beat_data", 32'(tdata_m), 32'(mon_b.data));
        check("beat_last", 32'(tlast_m), 32'(mon_b.last));
        check("beat_user", 32'(tuser_m), 32'(mon_b.user));
      end
    end
  end

  task automatic send(input logic [11:0] d);
    adc_data_i  = d;
    adc_valid_i = 1'b1;
    @(posedge hclk);
    #1;
    adc_valid_i = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 50; i++) begin
      if (q.size() == 0) break;
      @(posedge hclk);
    end
    @(posedge hclk);
    #1;
    check({name, "_pending"}, 32'(q.size()), 32'd0);
    check({name, "_idle"}, 32'(tvalid_m), 32'd0);
  endtask

  task automatic do_reset();
    hresetn = 1'b0;
    q.delete();
    m_frame = 0;
    m_pend  = 1'b1;
    #3;
    @(negedge hclk);
    hresetn = 1'b1;
    @(posedge hclk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    hresetn = 1'b0; ce = 1'b1; adc_data_i = '0; adc_valid_i = 1'b0;
    dec_log2_i = 3'd0; ovf_clr_i = 1'b0; tready_m = 1'b1;
    #12;
    check("rst_tdata", 32'(tdata_m), 32'h0);
    check("rst_tvalid", 32'(tvalid_m), 32'h0);
    check("rst_tlast", 32'(tlast_m), 32'h0);
    check("rst_tuser", 32'(tuser_m), 32'h0);
    check("rst_ovf_cnt", 32'(ovf_cnt_o), 32'h0);
    check("rst_ovf", 32'(ovf_o), 32'h0);
    @(negedge hclk);
    hresetn = 1'b1;
    @(posedge hclk);
    #1;

    // Pass-through, one-cycle latency.
    dec_log2_i = 3'd0;
    exp_push(16'h0000, 1'b1); send(12'h800);
    check("pt0_valid", 32'(tvalid_m), 32'd1);
    check("pt0_data", 32'(tdata_m), 32'h0000);
    exp_push(16'h7FF0, 1'b1); send(12'hFFF);
    check("pt1_data", 32'(tdata_m), 32'h7FF0);
    exp_push(16'h8000, 1'b1); send(12'h000);
    check("pt2_data", 32'(tdata_m), 32'h8000);
    wait_drain("pt");

    // N=2 average of 0x100 and negative floor (-3/4 -> -1).
    dec_log2_i = 3'd2;
    for (int i = 0; i < 3; i++) send(12'h900);
    exp_push(16'h1000, 1'b1); send(12'h900);
    for (int i = 0; i < 3; i++) send(12'h7FF);
    exp_push(16'hFFF0, 1'b1); send(12'h800);
    wait_drain("avg2");

    // N=7 with 128 samples of -1.
    dec_log2_i = 3'd7;
    for (int i = 0; i < 127; i++) send(12'h7FF);
    exp_push(16'hFFF0, 1'b1); send(12'h7FF);
    wait_drain("avg7");

    // N=1 half-LSB: truncation vs round-half-up.
    dec_log2_i = 3'd1;
    send(12'h801);
`ifdef ADC_DEC_ROUND_EN
    exp_push(16'h0010, 1'b1);
`else
    exp_push(16'h0000, 1'b1);
`endif
    send(12'h800);
    wait_drain("round");

    // Backpressure: two kept, three dropped; then clear, then clear colliding with a drop.
    do_reset();
    dec_log2_i = 3'd0;
    tready_m   = 1'b0;
    exp_push(16'h0100, 1'b1); send(12'h810);
    exp_push(16'h0200, 1'b1); send(12'h820);
    exp_push(16'h0300, 1'b0); send(12'h830);
    exp_push(16'h0400, 1'b0); send(12'h840);
    exp_push(16'h0500, 1'b0); send(12'h850);
    check("bp_ovf_cnt", 32'(ovf_cnt_o), 32'd3);
    check("bp_ovf", 32'(ovf_o), 32'd1);
    check("bp_hold_data", 32'(tdata_m), 32'h0100);
    ovf_clr_i = 1'b1;
    @(posedge hclk);
    #1;
    ovf_clr_i = 1'b0;
    check("clr_ovf_cnt", 32'(ovf_cnt_o), 32'd0);
    check("clr_ovf", 32'(ovf_o), 32'd0);
    ovf_clr_i = 1'b1;
    exp_push(16'h0600, 1'b0); send(12'h860);
    ovf_clr_i = 1'b0;
    check("clrdrop_ovf_cnt", 32'(ovf_cnt_o), 32'd1);
    check("clrdrop_ovf", 32'(ovf_o), 32'd1);
    tready_m = 1'b1;
    wait_drain("bp");

    // Frame tagging: tlast on beats 4 and 8.
    do_reset();
    dec_log2_i = 3'd0;
    for (int i = 0; i < 9; i++) begin
      exp_push(16'(i + 1) << 4, 1'b1);
      send(12'h801 + 12'(i));
      check("frame_tlast", 32'(tlast_m), ((i == 3) || (i == 7)) ? 32'd1 : 32'd0);
    end
    // Partial N=3 window discarded by a one-cycle ce drop; frame restarts with tuser.
    dec_log2_i = 3'd3;
    for (int i = 0; i < 3; i++) send(12'hFFF);
    ce = 1'b0;
    @(posedge hclk);
    #1;
    ce = 1'b1;
    m_frame = 0;
    m_pend  = 1'b1;
    for (int i = 0; i < 7; i++) send(12'h880);
    exp_push(16'h0800, 1'b1); send(12'h880);
    check("ce_tuser", 32'(tuser_m), 32'd1);
    dec_log2_i = 3'd0;
    for (int i = 0; i < 3; i++) begin
      exp_push(16'(i + 1) << 4, 1'b1);
      send(12'h801 + 12'(i));
    end
    check("ce_frame_tlast", 32'(tlast_m), 32'd1);
    wait_drain("frame");

    // Async reset with one buffered result and a half window pending.
    do_reset();
    tready_m   = 1'b0;
    dec_log2_i = 3'd0;
    send(12'h900);
    dec_log2_i = 3'd2;
    send(12'h900);
    send(12'h900);
    #2;
    hresetn = 1'b0;
    q.delete();
    m_frame = 0;
    m_pend  = 1'b1;
    #1;
    check("arst_tvalid", 32'(tvalid_m), 32'd0);
    check("arst_tdata", 32'(tdata_m), 32'd0);
    check("arst_tuser", 32'(tuser_m), 32'd0);
    @(negedge hclk);
    hresetn = 1'b1;
    @(posedge hclk);
    #1;
    tready_m = 1'b1;
    for (int i = 0; i < 3; i++) send(12'h840);
    exp_push(16'h0400, 1'b1); send(12'h840);
    check("arst_after_data", 32'(tdata_m), 32'h0400);
    wait_drain("arst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/adc_sample_decimator.md
# adc_sample_decimator

Front-end stage that sits directly upstream of `dsp_subsystem`, between the ADC capture pins and the subsystem's AXI-Stream slave (`tdata_s`/`tvalid_s`/`tready_s`). It converts offset-binary ADC samples to two's complement and averages non-overlapping windows of 2^N samples (boxcar decimation). Results are left-aligned into a 16-bit stream and buffered in a 2-entry FIFO, with frame/start markers and overflow accounting.

## Interface
- `DW_IN`, 12: ADC sample width (offset binary); must be ≤ DW.
- `DW`, 16: output stream width.
- `FRAME_LEN`, 1024: pushed results per frame (`tlast` period); must be ≥ 2.
- `hclk` in 1: clock.
- `hresetn` in 1: reset, asynchronous, active-low.
- `ce` in 1: enable; low clears accumulation and frame state.
- `adc_data_i` in DW_IN: raw ADC sample, offset binary.
- `adc_valid_i` in 1: sample strobe; one sample per cycle max.
- `dec_log2_i` in 3: N, window = 2^N samples (1..128).
- `ovf_clr_i` in 1: pulse, clears `ovf_cnt_o` and `ovf_o`.
- `tdata_m` out DW: averaged sample, two's complement, left-aligned.
- `tvalid_m` out 1: AXI-Stream valid.
- `tready_m` in 1: AXI-Stream ready.
- `tlast_m` out 1: last beat of frame.
- `tuser_m` out 1: first beat after `ce` rises.
- `ovf_cnt_o` out 16: dropped-result count, saturating.
- `ovf_o` out 1: sticky drop flag.

## Operation
- Sample accepted on rising `hclk` when `ce & adc_valid_i`; converted as `{~adc_data_i[DW_IN-1], adc_data_i[DW_IN-2:0]}` (signed).
- Accumulator width DW_IN+7 bits, signed; window counter 7 bits.
- `dec_log2_i` latched when the window counter is 0; changes mid-window take effect at the next window.
- Result on the last sample of the window: `(acc + sample) >>> N` (arithmetic), truncated to DW_IN bits, then `<< (DW-DW_IN)`. N=0 is a pass-through.
- Result pushed to the FIFO together with its `tlast`/`tuser` tags. Accumulator and counter reset to 0 on the same edge.
- Frame counter counts pushes (dropped results included); `tlast` is tagged on push FRAME_LEN-1, then the counter wraps to 0.
- `tuser` is tagged on the first push after `ce` goes 0→1, and on the first push after reset.
- `ce` low: accumulator, window counter and frame counter are held at 0; the partial window is discarded. FIFO contents are retained and continue to drain.
- FIFO full at push without a same-cycle pop: the new result is dropped and the FIFO is unchanged. `ovf_cnt_o` increments (saturates at 0xFFFF) and `ovf_o` is set.
- Push with a same-cycle pop while full: accepted, no drop.
- `ovf_clr_i` coinciding with a drop: `ovf_cnt_o`=1, `ovf_o`=1.

## Timing
- Reset values: `tdata_m`=0, `tvalid_m`=0, `tlast_m`=0, `tuser_m`=0, `ovf_cnt_o`=0, `ovf_o`=0. FIFO empty, all counters 0, `tuser` pending.
- Latency: `tvalid_m` is high in the cycle after the edge that captures a window's last sample. The FIFO output is registered; there is no combinational path from `adc_*` to `tdata_m`.
- AXI-Stream rules: a beat transfers when `tvalid_m & tready_m`. `tdata_m`/`tlast_m`/`tuser_m` are stable while `tvalid_m & ~tready_m`. `tvalid_m` does not depend on `tready_m`.
- Throughput: one beat per cycle sustained at N=0 with `tready_m` held high.
- `hresetn` asserted mid-window or mid-stream: everything returns to reset values immediately (asynchronous) and buffered results are lost.

## Configuration
- `ADC_DEC_ROUND_EN` defined: add 2^(N-1) (when N>0) before the arithmetic shift, i.e. round half up.
- Undefined: plain truncation (floor).
- The accumulator adds one guard bit when the macro is defined so the rounding add cannot overflow.

## Test plan
- Pass-through, N=0, `tready_m`=1: inputs 0x800, 0xFFF, 0x000 → `tdata_m` = 0x0000, 0x7FF0, 0x8000, each one cycle after its sample; first beat has `tuser_m`=1.
- Averaging, N=2: four samples of 0x900 → one beat 0x1000. N=7 with 128 samples of 0x7FF → 0xFFF0.
- Rounding, N=1: samples 0x801, 0x800 → 0x0000 without `ADC_DEC_ROUND_EN`, 0x0010 with it.
- Backpressure, N=0, `tready_m`=0: 5 samples → FIFO holds the first 2, `ovf_cnt_o`=3, `ovf_o`=1. `ovf_clr_i` pulse → 0/0. `tready_m`=1 → 2 beats drain in order.
- Frame, FRAME_LEN=4, N=0: 9 samples → `tlast_m` on beats 4 and 8. Drop `ce` for 1 cycle mid-window at N=3 → partial window discarded, next beat has `tuser_m`=1 and the frame restarts.
- `hresetn` pulsed with 1 FIFO entry and a half window pending → all outputs 0 immediately; next full window yields the correct average with `tuser_m`=1.
